// File: rtl/arb_req_pkg.sv
// Shared definitions for the 8-port arbiter requester front end.
package arb_req_pkg;

    localparam int unsigned N_PORTS = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_REQ  = 2'd1,
        P_OWN  = 2'd2
    } port_st_e;

    // Index of the set bit; only meaningful for one-hot input.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [N_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_req_port.sv
// One client port: IDLE/REQ/OWN state machine plus its registered arbiter request.
module arb_req_port
    import arb_req_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic last,
    input  logic ready,
    input  logic win,        // accepted grant for this port
    input  logic force_rel,  // timeout release of the current owner
    input  logic bus_busy,   // bus owned now or being granted this cycle
    output logic pending,
    output logic req
);

    port_st_e st_q, st_d;
    logic     req_d;

    // Next-state: withdraw from REQ when valid drops, leave OWN on last beat or forced release.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            P_IDLE: if (valid) st_d = P_REQ;
            P_REQ: begin
                if (win)         st_d = P_OWN;
                else if (!valid) st_d = P_IDLE;
            end
            P_OWN: if ((valid & ready & last) | (ready & force_rel)) st_d = P_IDLE;
            default: st_d = P_IDLE;
        endcase
    end

    // Request is suppressed while any port owns (or is just winning) the bus.
    always_comb begin
        req_d = (st_d == P_REQ) & ~bus_busy;
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= P_IDLE;
            req  <= 1'b0;
        end else begin
            st_q <= st_d;
            req  <= req_d;
        end
    end

    assign pending = (st_q == P_REQ);

endmodule

// File: rtl/arb_req_if_8.sv
// Requester-side front end of the 8-port tree arbiter: per-port request FSMs, grant legality
// check, local bus-ownership lock and owner index mux.
// Optional feature macro: ARB_REQ_TIMEOUT_EN (burst-length and idle timeouts on the owner).
module arb_req_if_8
    import arb_req_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 16,
    parameter int unsigned IDLE_LIM  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_PORTS-1:0] cli_valid,
    input  logic [N_PORTS-1:0] cli_last,
    output logic [N_PORTS-1:0] cli_ready,
    output logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] grant,
    output logic               owner_vld,
    output logic [IDX_W-1:0]   owner_idx,
    output logic               xfer,
    output logic               err_grant,
    output logic               err_timeout
);

    logic               owner_vld_q;
    logic [IDX_W-1:0]   owner_idx_q;
    logic               err_grant_q;
    logic [N_PORTS-1:0] pending;
    logic               grant_onehot, grant_ok, grant_bad;
    logic               last_beat, release_bus, force_rel;

    // A grant is accepted only when one-hot, aimed at a requesting port, and the bus is free.
    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
        grant_ok     = grant_onehot & (|(grant & pending)) & ~owner_vld_q;
        grant_bad    = (|grant) & ~grant_ok;
    end

    assign cli_ready   = owner_vld_q ? ({{(N_PORTS-1){1'b0}}, 1'b1} << owner_idx_q) : '0;
    assign xfer        = |(cli_valid & cli_ready);
    assign last_beat   = xfer & (|(cli_last & cli_ready));
    assign release_bus = last_beat | force_rel;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        arb_req_port u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .valid     (cli_valid[i]),
            .last      (cli_last[i]),
            .ready     (cli_ready[i]),
            .win       (grant_ok & grant[i]),
            .force_rel (force_rel),
            .bus_busy  (owner_vld_q | grant_ok),
            .pending   (pending[i]),
            .req       (req[i])
        );
    end

    // Owner registers; owner_idx keeps its last value after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_vld_q <= 1'b0;
            owner_idx_q <= '0;
            err_grant_q <= 1'b0;
        end else begin
            if (grant_ok) begin
                owner_vld_q <= 1'b1;
                owner_idx_q <= onehot2idx(grant);
            end else if (release_bus) begin
                owner_vld_q <= 1'b0;
            end
            err_grant_q <= err_grant_q | grant_bad;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    logic [4:0] beat_cnt_q;
    logic [6:0] idle_cnt_q;
    logic       err_timeout_q;
    logic       beat_hit, idle_hit;

    // The MAX_BEATS-th beat still transfers, then ownership is cut.
    assign beat_hit  = xfer & ~last_beat & (beat_cnt_q == 5'(MAX_BEATS - 1));
    assign idle_hit  = owner_vld_q & ~xfer & (idle_cnt_q == 7'(IDLE_LIM - 1));
    assign force_rel = beat_hit | idle_hit;

    // Beat and consecutive-idle counters for the current owner, cleared at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (grant_ok) begin
                beat_cnt_q <= '0;
                idle_cnt_q <= '0;
            end else if (owner_vld_q) begin
                if (xfer) begin
                    beat_cnt_q <= beat_cnt_q + 5'd1;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 7'd1;
                end
            end
            err_timeout_q <= err_timeout_q | force_rel;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign force_rel   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign owner_vld = owner_vld_q;
    assign owner_idx = owner_idx_q;
    assign err_grant = err_grant_q;

endmodule

// File: tb/tb_arb_req_if_8.sv
// Self-checking bench for arb_req_if_8: a transaction-level ownership model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_arb_req_if_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] cli_valid, cli_last, grant;
    logic [7:0] cli_ready, req;
    logic       owner_vld, xfer, err_grant, err_timeout;
    logic [2:0] owner_idx;

    int n_chk = 0;
    int n_err = 0;
    int xfer_cnt = 0;

    arb_req_if_8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cli_valid   (cli_valid),
        .cli_last    (cli_last),
        .cli_ready   (cli_ready),
        .req         (req),
        .grant       (grant),
        .owner_vld   (owner_vld),
        .owner_idx   (owner_idx),
        .xfer        (xfer),
        .err_grant   (err_grant),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Model: one owner (or none), the set of ports waiting for a grant, and the visible requests.
    int         m_owner;
    logic [2:0] m_idx;
    logic [7:0] m_pend, m_req;
    logic       m_eg, m_et;
    int         m_beats, m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_idx = 3'd0; m_pend = 8'h00; m_req = 8'h00;
            m_eg = 1'b0; m_et = 1'b0; m_beats = 0; m_idle = 0;
        end else begin
            int  ow, win;
            bit  owned, beat, fin, frc;
            ow    = m_owner;
            owned = (ow >= 0);
            beat  = owned && cli_valid[ow];
            fin   = beat && cli_last[ow];
            frc   = 1'b0;
            win   = -1;
            if (grant != 8'h00) begin
                if (!owned && $countones(grant) == 1 && m_pend[first_set(grant)])
                    win = first_set(grant);
                else
                    m_eg = 1'b1;
            end
`ifdef ARB_REQ_TIMEOUT_EN
            if (owned) begin
                if (beat) begin
                    m_beats++;
                    m_idle = 0;
                    if (m_beats == 16 && !fin) frc = 1'b1;
                end else begin
                    m_idle++;
                    if (m_idle == 64) frc = 1'b1;
                end
            end
            if (frc) m_et = 1'b1;
`endif
            // A port waits for a grant exactly while it asserts valid and neither owns nor just won.
            for (int i = 0; i < 8; i++) begin
                if ((owned && i == ow) || i == win) m_pend[i] = 1'b0;
                else                                m_pend[i] = cli_valid[i];
            end
            for (int i = 0; i < 8; i++) m_req[i] = m_pend[i] && !owned && (win < 0);
            if (fin || frc) m_owner = -1;
            if (win >= 0) begin
                m_owner = win; m_idx = 3'(win); m_beats = 0; m_idle = 0;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [7:0] er;
        er = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        chk("cli_ready",   cli_ready,            er);
        chk("req",         req,                  m_req);
        chk("owner_vld",   {7'b0, owner_vld},    {7'b0, (m_owner >= 0)});
        chk("owner_idx",   {5'b0, owner_idx},    {5'b0, m_idx});
        chk("xfer",        {7'b0, xfer},         {7'b0, |(cli_valid & er)});
        chk("err_grant",   {7'b0, err_grant},    {7'b0, m_eg});
        chk("err_timeout", {7'b0, err_timeout},  {7'b0, m_et});
        if (xfer) xfer_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cli_valid = 8'h00; cli_last = 8'h00; grant = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] oh;

        rst_n = 1'b0; cli_valid = 8'h00; cli_last = 8'h00; grant = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cli_ready, 8'h00);
        chk("rst_req",   req,       8'h00);
        chk("rst_own",   {7'b0, owner_vld}, 8'h00);
        chk("rst_idx",   {5'b0, owner_idx}, 8'h00);
        chk("rst_err",   {6'b0, err_grant, err_timeout}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 1: single port, three-beat burst.
        cli_valid = 8'h04;
        step();
        chk("t1_req", req, 8'h04);
        grant = 8'h04;
        step();
        grant = 8'h00;
        base = xfer_cnt;
        chk("t1_ready", cli_ready, 8'h04);
        chk("t1_req_own", req, 8'h00);
        chk("t1_idx", {5'b0, owner_idx}, 8'd2);
        step();
        step();
        cli_last = 8'h04;
        step();
        cli_valid = 8'h00; cli_last = 8'h00;
        chk("t1_xfers", 8'(xfer_cnt - base), 8'd3);
        chk("t1_released", {7'b0, owner_vld}, 8'h00);
        step();
        chk("t1_idle_req", req, 8'h00);

        // 2: full contention, grants in index order, single-beat bursts.
        cli_valid = 8'hFF;
        step();
        chk("t2_req_all", req, 8'hFF);
        for (int k = 0; k < 8; k++) begin
            oh = 8'(1 << k);
            grant = oh;
            step();
            grant = 8'h00;
            chk("t2_idx", {5'b0, owner_idx}, 8'(k));
            chk("t2_ready", cli_ready, oh);
            chk("t2_req_own", req, 8'h00);
            cli_last = oh;
            step();
            cli_last = 8'h00;
            chk("t2_req_gap", req, 8'h00);
            step();
        end
        cli_valid = 8'h00;
        step();
        step();

        // 3: illegal grants: multi-hot, then on an idle port.
        do_reset();
        cli_valid = 8'h11;
        step();
        grant = 8'h11;
        step();
        grant = 8'h00;
        chk("t3_multi_own", {7'b0, owner_vld}, 8'h00);
        chk("t3_multi_err", {7'b0, err_grant}, 8'h01);
        cli_valid = 8'h00;
        do_reset();
        grant = 8'h08;
        step();
        grant = 8'h00;
        chk("t3_idle_own", {7'b0, owner_vld}, 8'h00);
        step();
        step();
        chk("t3_sticky", {7'b0, err_grant}, 8'h01);

        // 4: grant while owned, then last beat coinciding with a grant.
        do_reset();
        cli_valid = 8'h21;
        step();
        grant = 8'h20;
        step();
        grant = 8'h00;
        chk("t4_idx", {5'b0, owner_idx}, 8'd5);
        chk("t4_err0", {7'b0, err_grant}, 8'h00);
        grant = 8'h01;
        step();
        grant = 8'h00;
        chk("t4_err", {7'b0, err_grant}, 8'h01);
        chk("t4_keep", {5'b0, owner_idx}, 8'd5);
        chk("t4_keep_vld", {7'b0, owner_vld}, 8'h01);
        cli_last = 8'h20; grant = 8'h01;
        step();
        cli_last = 8'h00; grant = 8'h00; cli_valid = 8'h00;
        chk("t4_rel", {7'b0, owner_vld}, 8'h00);
        chk("t4_hold_idx", {5'b0, owner_idx}, 8'd5);
        step();

        // 5: withdraw before grant.
        do_reset();
        cli_valid = 8'h40;
        step();
        step();
        chk("t5_req", req, 8'h40);
        cli_valid = 8'h00;
        step();
        chk("t5_drop", req, 8'h00);
        step();
        grant = 8'h40;
        step();
        grant = 8'h00;
        chk("t5_err", {7'b0, err_grant}, 8'h01);
        chk("t5_own", {7'b0, owner_vld}, 8'h00);

        // 6: 20-beat stream with last only on beat 20.
        do_reset();
        cli_valid = 8'h02;
        step();
        grant = 8'h02;
        step();
        grant = 8'h00;
        base = xfer_cnt;
        for (int b = 1; b <= 20; b++) begin
            if (b == 20) cli_last = 8'h02;
            step();
        end
        cli_valid = 8'h00; cli_last = 8'h00;
`ifdef ARB_REQ_TIMEOUT_EN
        chk("t6_xfers", 8'(xfer_cnt - base), 8'd16);
        chk("t6_err_to", {7'b0, err_timeout}, 8'h01);
`else
        chk("t6_xfers", 8'(xfer_cnt - base), 8'd20);
        chk("t6_err_to", {7'b0, err_timeout}, 8'h00);
`endif
        chk("t6_rel", {7'b0, owner_vld}, 8'h00);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
